// File: rtl/iq_filter_scheduler.sv
// Shares one pulse-shaping filter between the I and Q rails: zero-stuffs symbols to the upsampling rate,
// interleaves I/Q issues and re-pairs filter results. Optional macro UNDERRUN_CNT_EN adds an underrun counter.
module iq_filter_scheduler #(
  parameter int SAMP_W = 12,
  parameter int OUT_W  = 10,
  parameter int RATE_W = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [RATE_W-1:0] upsampling_rate,
  input  logic              sym_valid,
  output logic              sym_ready,
  input  logic [SAMP_W-1:0] sym_i,
  input  logic [SAMP_W-1:0] sym_q,
  output logic [SAMP_W-1:0] filt_data,
  output logic              filt_valid,
  output logic              filt_sel,
  input  logic [SAMP_W-1:0] filt_result,
  input  logic              filt_result_valid,
  output logic [OUT_W-1:0]  I_out,
  output logic [OUT_W-1:0]  Q_out,
  output logic              out_valid,
`ifdef UNDERRUN_CNT_EN
  output logic [15:0]       underrun_cnt,
`endif
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ISSUE_I, ISSUE_Q} state_t;

  state_t            state, state_next;
  logic [RATE_W-1:0] slot, slot_next;
  logic [RATE_W-1:0] rate_eff, rate_eff_next;
  logic [SAMP_W-1:0] held_i, held_i_next;
  logic [SAMP_W-1:0] held_q, held_q_next;
  logic [RATE_W-1:0] rate_in;
  logic              last_slot;

  logic              toggle_q;
  logic [SAMP_W-1:0] held_res;

  // A programmed rate of 0 is treated the same as 1 so every symbol issues at least once.
  assign rate_in   = (upsampling_rate == '0) ? RATE_W'(1) : upsampling_rate;
  assign last_slot = (slot == (rate_eff - RATE_W'(1)));
  assign busy      = (state != IDLE);

  always_comb begin
    state_next    = state;
    slot_next     = slot;
    rate_eff_next = rate_eff;
    held_i_next   = held_i;
    held_q_next   = held_q;
    sym_ready     = 1'b0;
    case (state)
      IDLE: begin
        sym_ready = 1'b1;
        if (sym_valid) begin
          held_i_next   = sym_i;
          held_q_next   = sym_q;
          rate_eff_next = rate_in;
          slot_next     = '0;
          state_next    = ISSUE_I;
        end
      end
      ISSUE_I: state_next = ISSUE_Q;
      ISSUE_Q: begin
        if (!last_slot) begin
          slot_next  = slot + RATE_W'(1);
          state_next = ISSUE_I;
        end else begin
          // Accepting here keeps the filter stream gap-free between symbols.
          sym_ready = 1'b1;
          if (sym_valid) begin
            held_i_next   = sym_i;
            held_q_next   = sym_q;
            rate_eff_next = rate_in;
            slot_next     = '0;
            state_next    = ISSUE_I;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
    if (rst) begin
      sym_ready = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      slot     <= '0;
      rate_eff <= '0;
      held_i   <= '0;
      held_q   <= '0;
    end else begin
      state    <= state_next;
      slot     <= slot_next;
      rate_eff <= rate_eff_next;
      held_i   <= held_i_next;
      held_q   <= held_q_next;
    end
  end

  // Filter-side outputs lag the state by one cycle; non-zero data only in slot 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      filt_valid <= 1'b0;
      filt_sel   <= 1'b0;
      filt_data  <= '0;
    end else begin
      filt_valid <= (state != IDLE);
      filt_sel   <= (state == ISSUE_Q);
      if (state == IDLE || slot != '0) begin
        filt_data <= '0;
      end else if (state == ISSUE_Q) begin
        filt_data <= held_q;
      end else begin
        filt_data <= held_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      toggle_q  <= 1'b0;
      held_res  <= '0;
      I_out     <= '0;
      Q_out     <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (filt_result_valid) begin
        if (!toggle_q) begin
          held_res <= filt_result;
          toggle_q <= 1'b1;
        end else begin
          I_out     <= held_res[SAMP_W-1 -: OUT_W];
          Q_out     <= filt_result[SAMP_W-1 -: OUT_W];
          out_valid <= 1'b1;
          toggle_q  <= 1'b0;
        end
      end
    end
  end

`ifdef UNDERRUN_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      underrun_cnt <= '0;
    end else if (state == ISSUE_Q && last_slot && !sym_valid && underrun_cnt != 16'hFFFF) begin
      underrun_cnt <= underrun_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_iq_filter_scheduler.sv
// Scoreboard bench for iq_filter_scheduler: expected filter issues and output pairs are queued by the
// stimulus and popped by a negedge monitor. Underrun checks run when UNDERRUN_CNT_EN is defined.
module tb_iq_filter_scheduler;
  localparam int SAMP_W = 12;
  localparam int OUT_W  = 10;
  localparam int RATE_W = 9;

  logic              clk;
  logic              rst;
  logic [RATE_W-1:0] upsampling_rate;
  logic              sym_valid;
  logic              sym_ready;
  logic [SAMP_W-1:0] sym_i;
  logic [SAMP_W-1:0] sym_q;
  logic [SAMP_W-1:0] filt_data;
  logic              filt_valid;
  logic              filt_sel;
  logic [SAMP_W-1:0] filt_result;
  logic              filt_result_valid;
  logic [OUT_W-1:0]  I_out;
  logic [OUT_W-1:0]  Q_out;
  logic              out_valid;
  logic              busy;
`ifdef UNDERRUN_CNT_EN
  logic [15:0]       underrun_cnt;
`endif

  iq_filter_scheduler #(.SAMP_W(SAMP_W), .OUT_W(OUT_W), .RATE_W(RATE_W)) dut (
    .clk(clk),
    .rst(rst),
    .upsampling_rate(upsampling_rate),
    .sym_valid(sym_valid),
    .sym_ready(sym_ready),
    .sym_i(sym_i),
    .sym_q(sym_q),
    .filt_data(filt_data),
    .filt_valid(filt_valid),
    .filt_sel(filt_sel),
    .filt_result(filt_result),
    .filt_result_valid(filt_result_valid),
    .I_out(I_out),
    .Q_out(Q_out),
    .out_valid(out_valid),
`ifdef UNDERRUN_CNT_EN
    .underrun_cnt(underrun_cnt),
`endif
    .busy(busy)
  );

  typedef struct packed {
    logic              sel;
    logic [SAMP_W-1:0] data;
  } issue_t;

  issue_t             issue_q[$];
  logic [2*OUT_W-1:0] pair_q[$];

  int checks;
  int failures;
  bit mon_en;
  int busy_cycles;
  int ready_busy;
  int run_len;
  int max_run;
  int out_pulses;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a filter issue or an output pair.
  always @(negedge clk) begin
    if (mon_en) begin
      if (busy) busy_cycles++;
      if (sym_ready && busy) ready_busy++;
      if (filt_valid) begin
        issue_t e;
        run_len++;
        if (run_len > max_run) max_run = run_len;
        check_output("issue_expected", 32'(issue_q.size() != 0), 32'd1);
        if (issue_q.size() != 0) begin
          e = issue_q.pop_front();
          check_output("filt_sel", 32'(filt_sel), 32'(e.sel));
          check_output("filt_data", 32'(filt_data), 32'(e.data));
        end
      end else begin
        run_len = 0;
      end
      if (out_valid) begin
        logic [2*OUT_W-1:0] p;
        out_pulses++;
        check_output("pair_expected", 32'(pair_q.size() != 0), 32'd1);
        if (pair_q.size() != 0) begin
          p = pair_q.pop_front();
          check_output("I_out", 32'(I_out), 32'(p[2*OUT_W-1:OUT_W]));
          check_output("Q_out", 32'(Q_out), 32'(p[OUT_W-1:0]));
        end
      end
    end
  end

  task automatic clear_counts();
    busy_cycles = 0;
    ready_busy  = 0;
    max_run     = 0;
  endtask

  // Presents a symbol and waits for acceptance; queues up to max_issues expected filter issues.
  task automatic send_symbol(input logic [SAMP_W-1:0] si, input logic [SAMP_W-1:0] sq,
                             input logic [RATE_W-1:0] rate_drive, input int rate_exp,
                             input int max_issues);
    bit ok;
    issue_t e;
    upsampling_rate = rate_drive;
    sym_i = si;
    sym_q = sq;
    sym_valid = 1'b1;
    for (int k = 0; k < 2 * rate_exp && k < max_issues; k++) begin
      e.sel  = k[0];
      e.data = (k < 2) ? (k[0] ? sq : si) : '0;
      issue_q.push_back(e);
    end
    ok = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      if (sym_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check_output("accept_in_time", 32'(ok), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    check_output("idle_in_time", 32'(ok), 32'd1);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic send_result(input logic [SAMP_W-1:0] r);
    filt_result = r;
    filt_result_valid = 1'b1;
    @(posedge clk);
    #1;
    filt_result_valid = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_sym_ready"}, 32'(sym_ready), 32'd0);
    check_output({tag, "_filt_data"}, 32'(filt_data), 32'd0);
    check_output({tag, "_filt_valid"}, 32'(filt_valid), 32'd0);
    check_output({tag, "_filt_sel"}, 32'(filt_sel), 32'd0);
    check_output({tag, "_I_out"}, 32'(I_out), 32'd0);
    check_output({tag, "_Q_out"}, 32'(Q_out), 32'd0);
    check_output({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check_output({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks = 0;
    failures = 0;
    mon_en = 1'b0;
    out_pulses = 0;
    run_len = 0;
    clear_counts();
    rst = 1'b1;
    sym_valid = 1'b0;
    sym_i = '0;
    sym_q = '0;
    upsampling_rate = 9'd1;
    filt_result = '0;
    filt_result_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst = 1'b0;
    mon_en = 1'b1;

    // Rate 1: one I issue, one Q issue.
    clear_counts();
    send_symbol(12'h2A0, 12'hD60, 9'd1, 1, 1000);
    sym_valid = 1'b0;
    wait_idle();
    check_output("r1_busy_cycles", 32'(busy_cycles), 32'd2);
    check_output("r1_ready_while_busy", 32'(ready_busy), 32'd1);
    check_output("r1_idle_ready", 32'(sym_ready), 32'd1);

    // Rate 4: eight issues, six of them zero-stuffed.
    clear_counts();
    send_symbol(12'h100, 12'h300, 9'd4, 4, 1000);
    sym_valid = 1'b0;
    wait_idle();
    check_output("r4_busy_cycles", 32'(busy_cycles), 32'd8);
    check_output("r4_run", 32'(max_run), 32'd8);

    // Rate 2, three symbols back to back.
    clear_counts();
    send_symbol(12'h011, 12'h022, 9'd2, 2, 1000);
    send_symbol(12'h033, 12'h044, 9'd2, 2, 1000);
    send_symbol(12'h055, 12'h066, 9'd2, 2, 1000);
    sym_valid = 1'b0;
    wait_idle();
    check_output("b2b_run", 32'(max_run), 32'd12);
    check_output("b2b_ready_pulses", 32'(ready_busy), 32'd3);
    check_output("b2b_busy_cycles", 32'(busy_cycles), 32'd12);

    // Result pairing with truncation, then a lone unpaired result.
    pair_q.push_back({10'h2AF, 10'h048});
    send_result(12'hABC);
    send_result(12'h123);
    repeat (3) @(negedge clk);
    check_output("pair_pulses", 32'(out_pulses), 32'd1);
    send_result(12'h555);
    repeat (3) @(negedge clk);
    check_output("unpaired_pulses", 32'(out_pulses), 32'd1);
    @(posedge clk);
    #1;

    // Rate 0 behaves as rate 1.
    clear_counts();
    send_symbol(12'h7FF, 12'h801, 9'd0, 1, 1000);
    sym_valid = 1'b0;
    wait_idle();
    check_output("r0_busy_cycles", 32'(busy_cycles), 32'd2);

    // Rate change mid-symbol only applies to the next capture.
    clear_counts();
    send_symbol(12'h010, 12'h020, 9'd2, 2, 1000);
    sym_valid = 1'b0;
    upsampling_rate = 9'd3;
    @(posedge clk);
    #1;
    send_symbol(12'h030, 12'h040, 9'd3, 3, 1000);
    sym_valid = 1'b0;
    wait_idle();
    check_output("ratechg_busy_cycles", 32'(busy_cycles), 32'd10);

    // Reset while in ISSUE_Q of slot 2 at rate 4; the pending unpaired result must be dropped too.
    send_symbol(12'hAAA, 12'h555, 9'd4, 4, 5);
    sym_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset_values("midrst");
    check_output("midrst_queue_drained", 32'(issue_q.size()), 32'd0);
    rst = 1'b0;
    pair_q.push_back({10'h100, 10'h1FF});
    send_result(12'h400);
    send_result(12'h7FC);
    repeat (3) @(negedge clk);
    check_output("postrst_pair_pulses", 32'(out_pulses), 32'd2);
    @(posedge clk);
    #1;

`ifdef UNDERRUN_CNT_EN
    send_symbol(12'h001, 12'h002, 9'd1, 1, 1000);
    sym_valid = 1'b0;
    wait_idle();
    send_symbol(12'h003, 12'h004, 9'd1, 1, 1000);
    sym_valid = 1'b0;
    wait_idle();
    check_output("underrun_two", 32'(underrun_cnt), 32'd2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_output("underrun_reset", 32'(underrun_cnt), 32'd0);
`endif

    repeat (3) @(negedge clk);
    check_output("issue_queue_empty", 32'(issue_q.size()), 32'd0);
    check_output("pair_queue_empty", 32'(pair_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
